// File: rtl/shift_sub_divider_pkg.sv
// Shared definitions for the shift/subtract divider: FSM encodings and default width.
package divider_defs;

    localparam int unsigned DefaultWordLength = 8;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StLoad2     = 3'd1,
        StWaitStart = 3'd2,
        StProcess   = 3'd3,
        StDone      = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_control.sv
// Divider sequencer: operand load handshake, iteration counter and result strobe.
module div_control
    import divider_defs::*;
#(
    parameter int unsigned WORD_LENGTH = DefaultWordLength
) (
    input  logic clk,
    input  logic reset,
    input  logic one_shot,
    input  logic start,
    input  logic divisor_zero,
    output logic load_dividend,
    output logic load_divisor,
    output logic start_process,
    output logic step,
    output logic finish,
    output logic ready,
    output logic loaded_1,
    output logic loaded_2,
    output logic busy
);

    localparam int unsigned CntWidth = $clog2(WORD_LENGTH + 1);
    localparam logic [CntWidth-1:0] LastCount = CntWidth'(WORD_LENGTH - 1);

    div_state_e state_q, state_d;
    logic [CntWidth-1:0] count_q, count_d;

    // State and iteration counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        load_dividend = 1'b0;
        load_divisor  = 1'b0;
        start_process = 1'b0;
        step          = 1'b0;
        finish        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (one_shot) begin
                    load_dividend = 1'b1;
                    state_d       = StLoad2;
                end
            end
            StLoad2: begin
                if (one_shot) begin
                    load_divisor = 1'b1;
                    state_d      = StWaitStart;
                end
            end
            StWaitStart: begin
                // Start takes priority; One_Shot is not looked at here.
                if (start) begin
                    if (divisor_zero) begin
                        state_d = StDone;
                    end else begin
                        start_process = 1'b1;
                        count_d       = '0;
                        state_d       = StProcess;
                    end
                end
            end
            StProcess: begin
                step    = 1'b1;
                count_d = count_q + 1'b1;
                if (count_q == LastCount) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                finish  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ready    = (state_q == StIdle);
    assign loaded_1 = (state_q == StLoad2);
    assign loaded_2 = (state_q == StWaitStart);
    assign busy     = (state_q == StProcess);

endmodule

// File: rtl/shift_sub_divider.sv
// Unsigned restoring divider: two-operand load via One_Shot, MSB-first shift/subtract.
module shift_sub_divider
    import divider_defs::*;
#(
    parameter int unsigned WORD_LENGTH = DefaultWordLength
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   One_Shot,
    input  logic                   Start,
    input  logic [WORD_LENGTH-1:0] Data,
    output logic                   Ready,
    output logic                   Loaded_1,
    output logic                   Loaded_2,
    output logic                   Busy,
    output logic                   Done,
    output logic [WORD_LENGTH-1:0] Quotient,
    output logic [WORD_LENGTH-1:0] Remainder,
    output logic                   Div_By_Zero
);

    logic load_dividend, load_divisor, start_process, step, finish;
    logic divisor_zero;

    logic [WORD_LENGTH-1:0] dividend_q, divisor_q;
    logic [WORD_LENGTH-1:0] dvd_sr_q, rem_q, quo_q;
    logic [WORD_LENGTH-1:0] quotient_q, remainder_q;
    logic                   dbz_q, done_q;

    logic [WORD_LENGTH:0]   shifted;
    logic [WORD_LENGTH:0]   trial;
    logic                   trial_neg;

    assign divisor_zero = (divisor_q == '0);

    div_control #(
        .WORD_LENGTH (WORD_LENGTH)
    ) u_div_control (
        .clk           (clk),
        .reset         (reset),
        .one_shot      (One_Shot),
        .start         (Start),
        .divisor_zero  (divisor_zero),
        .load_dividend (load_dividend),
        .load_divisor  (load_divisor),
        .start_process (start_process),
        .step          (step),
        .finish        (finish),
        .ready         (Ready),
        .loaded_1      (Loaded_1),
        .loaded_2      (Loaded_2),
        .busy          (Busy)
    );

    // Trial subtraction. The partial remainder is always below the divisor, so the
    // shifted value is below twice the divisor and a W+1-bit difference is exact:
    // its top bit is a true sign bit.
    always_comb begin
        shifted   = {rem_q, dvd_sr_q[WORD_LENGTH-1]};
        trial     = shifted - {1'b0, divisor_q};
        trial_neg = trial[WORD_LENGTH];
    end

    // Operand capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            dividend_q <= '0;
            divisor_q  <= '0;
        end else begin
            if (load_dividend) dividend_q <= Data;
            if (load_divisor)  divisor_q  <= Data;
        end
    end

    // Working registers: dividend bit feed, partial remainder, quotient shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            dvd_sr_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
        end else if (start_process) begin
            dvd_sr_q <= dividend_q;
            rem_q    <= '0;
            quo_q    <= '0;
        end else if (step) begin
            dvd_sr_q <= {dvd_sr_q[WORD_LENGTH-2:0], 1'b0};
            rem_q    <= trial_neg ? shifted[WORD_LENGTH-1:0] : trial[WORD_LENGTH-1:0];
            quo_q    <= {quo_q[WORD_LENGTH-2:0], ~trial_neg};
        end
    end

    // Result registers; only the DONE state updates them.
    always_ff @(posedge clk) begin
        if (reset) begin
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= finish;
            if (finish) begin
                if (divisor_zero) begin
                    quotient_q  <= '1;
                    remainder_q <= dividend_q;
                    dbz_q       <= 1'b1;
                end else begin
                    quotient_q  <= quo_q;
                    remainder_q <= rem_q;
                    dbz_q       <= 1'b0;
                end
            end
        end
    end

    assign Done        = done_q;
    assign Quotient    = quotient_q;
    assign Remainder   = remainder_q;
    assign Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed and randomized checks for shift_sub_divider at the default width.
module tb_shift_sub_divider;
    import divider_defs::*;

    localparam int unsigned W = DefaultWordLength;

    logic         clk = 1'b0;
    logic         reset;
    logic         One_Shot;
    logic         Start;
    logic [W-1:0] Data;
    logic         Ready, Loaded_1, Loaded_2, Busy, Done, Div_By_Zero;
    logic [W-1:0] Quotient, Remainder;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    shift_sub_divider #(
        .WORD_LENGTH (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .One_Shot    (One_Shot),
        .Start       (Start),
        .Data        (Data),
        .Ready       (Ready),
        .Loaded_1    (Loaded_1),
        .Loaded_2    (Loaded_2),
        .Busy        (Busy),
        .Done        (Done),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Div_By_Zero (Div_By_Zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input logic [W-1:0] v);
        Data     = v;
        One_Shot = 1'b1;
        tick();
        One_Shot = 1'b0;
    endtask

    // Edges after the current point until Done is seen, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (Done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic set_vec(input int i, input int a, input int b, input int q, input int r,
                           input int z, input int lat);
        vecs[i].a   = W'(a);
        vecs[i].b   = W'(b);
        vecs[i].q   = W'(q);
        vecs[i].r   = W'(r);
        vecs[i].z   = z[0];
        vecs[i].lat = lat;
    endtask

    initial begin
        int cyc;
        int seen;
        logic [W-1:0] ra, rb;
        logic ok;

        // Latency counted in edges after the Start edge: W+1 normally, 1 for zero divisor.
        set_vec(0, 100,   7,  14,   2, 0, 9);
        set_vec(1, 255,   1, 255,   0, 0, 9);
        set_vec(2,   3, 200,   0,   3, 0, 9);
        set_vec(3,   5,   0, 255,   5, 1, 1);
        set_vec(4, 200, 200,   1,   0, 0, 9);
        set_vec(5,   0,   9,   0,   0, 0, 9);
        set_vec(6, 255,  16,  15,  15, 0, 9);
        set_vec(7, 128,   3,  42,   2, 0, 9);
        set_vec(8,   0,   0, 255,   0, 1, 1);
        set_vec(9, 254, 255,   0, 254, 0, 9);

        reset    = 1'b1;
        One_Shot = 1'b0;
        Start    = 1'b0;
        Data     = '0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_ready", 32'(Ready), 1);
        check("rst_loaded_1", 32'(Loaded_1), 0);
        check("rst_loaded_2", 32'(Loaded_2), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_done", 32'(Done), 0);
        check("rst_quotient", 32'(Quotient), 0);
        check("rst_remainder", 32'(Remainder), 0);
        check("rst_dbz", 32'(Div_By_Zero), 0);

        for (int i = 0; i < 10; i++) begin
            load(vecs[i].a);
            check($sformatf("v%0d_loaded_1", i), 32'(Loaded_1), 1);
            load(vecs[i].b);
            check($sformatf("v%0d_loaded_2", i), 32'(Loaded_2), 1);
            Start = 1'b1;
            tick();
            Start = 1'b0;
            check($sformatf("v%0d_busy", i), 32'(Busy), (vecs[i].b != '0) ? 1 : 0);
            wait_done(cyc);
            check($sformatf("v%0d_latency", i), 32'(cyc), 32'(vecs[i].lat));
            check($sformatf("v%0d_quotient", i), 32'(Quotient), 32'(vecs[i].q));
            check($sformatf("v%0d_remainder", i), 32'(Remainder), 32'(vecs[i].r));
            check($sformatf("v%0d_dbz", i), 32'(Div_By_Zero), 32'(vecs[i].z));
            tick();
            check($sformatf("v%0d_done_pulse", i), 32'(Done), 0);
            check($sformatf("v%0d_q_hold", i), 32'(Quotient), 32'(vecs[i].q));
        end

        // Reset during the 4th PROCESS cycle aborts cleanly.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load(8'd100);
        load(8'd7);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        tick();
        check("abort_busy_before", 32'(Busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", 32'(Ready), 1);
        check("abort_busy", 32'(Busy), 0);
        check("abort_done", 32'(Done), 0);
        check("abort_quotient", 32'(Quotient), 0);
        check("abort_remainder", 32'(Remainder), 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (Done === 1'b1) seen = 1;
        end
        check("abort_no_done", 32'(seen), 0);
        check("abort_ready_hold", 32'(Ready), 1);

        // Start ignored in IDLE and LOAD_2; Start beats One_Shot in WAIT_START.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("ign_start_idle_ready", 32'(Ready), 1);
        check("ign_start_idle_busy", 32'(Busy), 0);
        load(8'd50);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("ign_start_load2", 32'(Loaded_1), 1);
        load(8'd6);
        Start    = 1'b1;
        One_Shot = 1'b1;
        Data     = 8'd99;
        tick();
        Start = 1'b0;
        check("start_wins_busy", 32'(Busy), 1);
        // One_Shot held for two PROCESS cycles must not disturb the operation.
        Data = 8'd1;
        tick();
        tick();
        One_Shot = 1'b0;
        check("ign_oneshot_busy", 32'(Busy), 1);
        wait_done(cyc);
        check("ign_oneshot_latency", 32'(cyc), 7);
        check("ign_oneshot_quotient", 32'(Quotient), 8);
        check("ign_oneshot_remainder", 32'(Remainder), 2);
        tick();
        // New operand loads leave the previous result untouched.
        load(8'd10);
        load(8'd3);
        check("hold_quotient", 32'(Quotient), 8);
        check("hold_remainder", 32'(Remainder), 2);
        check("hold_done", 32'(Done), 0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_done(cyc);
        check("after_hold_quotient", 32'(Quotient), 3);
        check("after_hold_remainder", 32'(Remainder), 1);
        tick();

        // Random sweep against the division identity.
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(1, (1 << W) - 1));
            load(ra);
            load(rb);
            Start = 1'b1;
            tick();
            Start = 1'b0;
            wait_done(cyc);
            ok = (cyc == int'(W) + 1) && (Div_By_Zero === 1'b0) &&
                 (int'(Quotient) * int'(rb) + int'(Remainder) == int'(ra)) &&
                 (Remainder < rb);
            if (!ok) begin
                $display("rand a=%0d b=%0d q=%0d r=%0d lat=%0d", ra, rb, Quotient, Remainder, cyc);
            end
            check($sformatf("rand%0d_identity", i), 32'(ok), 1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_sub_divider.md
SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 8, operand/result width in bits (legal range 2..16).
REQ-002 SHALL have port clk input 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset input 1: reset is synchronous and active-high.
REQ-004 SHALL have port One_Shot input 1: single-cycle load strobe from the debounced button.
REQ-005 SHALL have port Start input 1: begin-division request.
REQ-006 SHALL have port Data input WORD_LENGTH: operand bus, unsigned.
REQ-007 SHALL have port Ready output 1: high only in IDLE.
REQ-008 SHALL have port Loaded_1 output 1: high while the dividend is held and the divisor is awaited.
REQ-009 SHALL have port Loaded_2 output 1: high while both operands are held and Start is awaited.
REQ-010 SHALL have port Busy output 1: high in PROCESS.
REQ-011 SHALL have port Done output 1: one-cycle pulse when results update.
REQ-012 SHALL have port Quotient output WORD_LENGTH: registered result.
REQ-013 SHALL have port Remainder output WORD_LENGTH: registered result.
REQ-014 SHALL have port Div_By_Zero output 1: registered flag for the last completed division.

Function
REQ-015 SHALL implement states IDLE, LOAD_2, WAIT_START, PROCESS and DONE; any unused encoding SHALL go to IDLE.
REQ-016 IDLE: on One_Shot=1, SHALL capture Data as the dividend and go to LOAD_2; otherwise it SHALL stay in IDLE.
REQ-017 LOAD_2: on One_Shot=1, SHALL capture Data as the divisor and go to WAIT_START.
REQ-018 WAIT_START: on Start=1 with divisor nonzero, SHALL go to PROCESS and clear the iteration counter, partial remainder and quotient shift register.
REQ-019 WAIT_START: on Start=1 with divisor zero, SHALL go directly to DONE with the div-by-zero result.
REQ-020 Start SHALL be ignored in IDLE, LOAD_2, PROCESS and DONE; One_Shot SHALL be ignored in WAIT_START, PROCESS and DONE.
REQ-021 If Start and One_Shot are both high in WAIT_START, Start SHALL win.
REQ-022 PROCESS SHALL run exactly WORD_LENGTH cycles of restoring division, MSB first.
REQ-023 Each PROCESS cycle SHALL shift the partial remainder left one bit, inserting the next dividend bit.
REQ-024 Each PROCESS cycle SHALL form a WORD_LENGTH+1-bit trial difference (remainder minus divisor).
REQ-025 If the trial difference is non-negative, SHALL keep it and shift in quotient bit 1; otherwise SHALL restore and shift in 0.
REQ-026 The iteration counter SHALL be ceil(log2(WORD_LENGTH+1)) bits wide and SHALL not wrap within one operation.
REQ-027 After the last iteration, SHALL go to DONE.
REQ-028 DONE SHALL last one cycle: Done=1, Quotient, Remainder and Div_By_Zero SHALL load, then the FSM SHALL go to IDLE.
REQ-029 Latency: with Start sampled at edge k, Done SHALL be high in the cycle after edge k+WORD_LENGTH+1 (the cycle after edge k+1 for divisor zero).
REQ-030 Div-by-zero result SHALL be Quotient = all ones, Remainder = dividend, Div_By_Zero=1.
REQ-031 Quotient, Remainder and Div_By_Zero SHALL hold between DONE pulses; new operand loads SHALL not disturb them.
REQ-032 Dividend < divisor SHALL give Quotient=0 and Remainder=dividend.

Reset
REQ-033 On reset=1 at a clock edge, from any state including mid-PROCESS, SHALL go to IDLE; Quotient, Remainder, Div_By_Zero, Done, Busy, Loaded_1 and Loaded_2 SHALL be 0; Ready SHALL be 1; operand registers SHALL clear.
REQ-034 An aborted division SHALL produce no Done pulse and SHALL not change the result registers.

Structure
REQ-035 State encodings and the default WORD_LENGTH SHALL live in a shared definitions package, divider_defs, included by the RTL and the bench.
REQ-036 The FSM and iteration counter SHALL be the sub-module div_control; the shift/subtract datapath SHALL stay in the top module.

Verification (WORD_LENGTH=8)
REQ-037 Load 100, then 7, then Start -> Done 10 cycles after Start, Quotient=14, Remainder=2, Div_By_Zero=0.
REQ-038 Load 255, then 1, then Start -> Quotient=255, Remainder=0; load 3, then 200 -> Quotient=0, Remainder=3.
REQ-039 Load 5, then 0, then Start -> Done 2 cycles after Start, Quotient=255, Remainder=5, Div_By_Zero=1.
REQ-040 Pulse reset in the 4th PROCESS cycle -> next cycle IDLE, Ready=1, no Done, results still 0.
REQ-041 Start in IDLE and LOAD_2 -> ignored; One_Shot during PROCESS -> ignored and result unchanged.
REQ-042 Random sweep of 1,000 operand pairs -> Quotient*divisor+Remainder == dividend and Remainder < divisor.
